// File: rtl/counter_dump.sv
// counter_dump: snapshots two event counters on a request and streams them
// out as a framed byte sequence over a valid/ready link:
//   HEADER, In0 bytes MSB first, In1 bytes MSB first [, XOR checksum].
// Optional feature macro: DUMP_CHKSUM_EN appends the XOR of all payload bytes
// (HEADER excluded) as one extra trailing byte.
module counter_dump #(
    parameter int         CNT_W  = 64,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req,
    input  logic [CNT_W-1:0] In0,
    input  logic [CNT_W-1:0] In1,
    output logic [7:0]       Tx_Data,
    output logic             Tx_Valid,
    input  logic             Tx_Ready,
    output logic             Busy,
    output logic             Done,
    output logic [15:0]      Drop_Cnt
);

    localparam int NPAY = 2 * CNT_W / 8;
`ifdef DUMP_CHKSUM_EN
    localparam int NBYTES = NPAY + 2;
`else
    localparam int NBYTES = NPAY + 1;
`endif
    localparam logic [7:0] LAST_IDX = 8'(NBYTES - 1);
    // Index of the last payload byte; the byte after it (if any) is the checksum.
    localparam logic [7:0] PAY_END  = 8'(NPAY);

    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

    state_t               state_q, state_d;
    logic [2*CNT_W-1:0]   shreg_q, shreg_d;
    logic [7:0]           idx_q, idx_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [15:0]          drop_q, drop_d;
    logic [7:0]           top_byte;
    logic                 xfer;
`ifdef DUMP_CHKSUM_EN
    logic [7:0]           chk_q, chk_d;
`endif

    // Next-state logic: snapshot on request, advance one byte per accepted transfer.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        data_d   = data_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        drop_d   = drop_q;
`ifdef DUMP_CHKSUM_EN
        chk_d    = chk_q;
`endif
        top_byte = shreg_q[2*CNT_W-1 -: 8];
        xfer     = valid_q && Tx_Ready;

        unique case (state_q)
            IDLE, FIN: begin
                if (Req) begin
                    state_d = SEND;
                    shreg_d = {In0, In1};
                    idx_d   = 8'd0;
                    data_d  = HEADER;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef DUMP_CHKSUM_EN
                    chk_d   = 8'd0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                // Requests arriving mid-frame are counted, never queued.
                if (Req && drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = FIN;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 8'd1;
                        if (idx_q < PAY_END) begin
                            data_d  = top_byte;
                            shreg_d = shreg_q << 8;
`ifdef DUMP_CHKSUM_EN
                            chk_d   = chk_q ^ top_byte;
`endif
                        end
`ifdef DUMP_CHKSUM_EN
                        else begin
                            data_d = chk_q;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; synchronous reset abandons any frame in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= 8'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 16'd0;
`ifdef DUMP_CHKSUM_EN
            chk_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
`ifdef DUMP_CHKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    assign Tx_Data  = data_q;
    assign Tx_Valid = valid_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Drop_Cnt = drop_q;

endmodule

// File: tb/tb_counter_dump.sv
// Testbench for counter_dump: directed scenarios with randomized counter
// values and ready patterns, checked against a byte-list frame model.
`timescale 1ns/1ps
module tb_counter_dump;

    localparam int         CNT_W = 64;
    localparam logic [7:0] HDR   = 8'hA5;

    logic             Clk = 1'b0;
    logic             Reset, Req, Tx_Ready;
    logic [CNT_W-1:0] In0, In1;
    logic [7:0]       Tx_Data;
    logic             Tx_Valid, Busy, Done;
    logic [15:0]      Drop_Cnt;

    int passed = 0;
    int total  = 0;
    int exp_drop = 0;
    logic [7:0] exp_q[$];

    always #5 Clk = ~Clk;

    counter_dump #(.CNT_W(CNT_W), .HEADER(HDR)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req      (Req),
        .In0      (In0),
        .In1      (In1),
        .Tx_Data  (Tx_Data),
        .Tx_Valid (Tx_Valid),
        .Tx_Ready (Tx_Ready),
        .Busy     (Busy),
        .Done     (Done),
        .Drop_Cnt (Drop_Cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected frame: header, each counter as big-endian bytes, optional XOR.
    function automatic void build_frame(input logic [63:0] a, input logic [63:0] b);
        logic [7:0] x;
        logic [7:0] byt;
        x = 8'h00;
        exp_q.delete();
        exp_q.push_back(HDR);
        for (int i = CNT_W/8 - 1; i >= 0; i--) begin
            byt = 8'((a >> (8*i)) & 64'hFF);
            exp_q.push_back(byt);
            x ^= byt;
        end
        for (int i = CNT_W/8 - 1; i >= 0; i--) begin
            byt = 8'((b >> (8*i)) & 64'hFF);
            exp_q.push_back(byt);
            x ^= byt;
        end
`ifdef DUMP_CHKSUM_EN
        exp_q.push_back(x);
`endif
    endfunction

    task automatic start_frame(input logic [63:0] a, input logic [63:0] b, input bit keep_req);
        In0 = a;
        In1 = b;
        Req = 1'b1;
        build_frame(a, b);
        @(negedge Clk);
        if (!keep_req) Req = 1'b0;
        check("first_valid", 64'(Tx_Valid), 64'd1);
        check("busy_rise", 64'(Busy), 64'd1);
    endtask

    // rmode: 0 ready always, 1 pattern 1,0,0,1,0,1, 2 random.
    // qmode: 0 Req untouched, 1 Req pulses at cycles 2 and 5, 2 Req left high.
    task automatic recv_frame(input int rmode, input int qmode, input int abort_at,
                              input bit inc0, output bit aborted);
        int         k, cyc;
        bit         hold, early_done, rdy;
        logic [7:0] held;
        k = 0; cyc = 0; hold = 0; early_done = 0; held = 8'h00;
        aborted = 0;
        while (Tx_Valid === 1'b1) begin
            if (abort_at > 0 && k == abort_at) begin
                aborted = 1;
                break;
            end
            if (hold) check("hold_stable", 64'(Tx_Data), 64'(held));
            if (Done !== 1'b0) early_done = 1;
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 6 == 0) || (cyc % 6 == 3) || (cyc % 6 == 5);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            Tx_Ready = rdy;
            if (qmode == 1) Req = (cyc == 2 || cyc == 5);
            if (Req) exp_drop++;
            if (inc0) In0 = In0 + 1;
            if (rdy) begin
                if (k < exp_q.size())
                    check($sformatf("byte%0d", k), 64'(Tx_Data), 64'(exp_q[k]));
                else
                    check("frame_overrun", 64'(k), 64'(exp_q.size()));
                k++;
                hold = 0;
            end else begin
                hold = 1;
                held = Tx_Data;
            end
            @(negedge Clk);
            cyc++;
            if (cyc > 500) begin
                check("frame_timeout", 64'(cyc), 64'd0);
                break;
            end
        end
        Tx_Ready = 1'b0;
        if (qmode == 1) Req = 1'b0;
        if (!aborted) begin
            check("frame_len", 64'(k), 64'(exp_q.size()));
            check("no_early_done", 64'(early_done), 64'd0);
            check("done_pulse", 64'(Done), 64'd1);
            check("busy_fall", 64'(Busy), 64'd0);
        end
    endtask

    task automatic after_fin(input string tag);
        Req = 1'b0;
        @(negedge Clk);
        check({tag, "_done_low"}, 64'(Done), 64'd0);
        check({tag, "_idle"}, 64'(Tx_Valid), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ab;
        logic [63:0] a, b;
        Reset = 1'b1; Req = 1'b0; Tx_Ready = 1'b0; In0 = '0; In1 = '0;
        repeat (3) @(negedge Clk);
        check("rst_data", 64'(Tx_Data), 64'h00);
        check("rst_valid", 64'(Tx_Valid), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_drop", 64'(Drop_Cnt), 64'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Streaming 5/3 with ready always high.
        start_frame(64'h5, 64'h3, 1'b0);
        recv_frame(0, 0, 0, 1'b0, ab);
        after_fin("stream");

        // Same payload under backpressure.
        start_frame(64'h5, 64'h3, 1'b0);
        recv_frame(1, 0, 0, 1'b0, ab);
        after_fin("bp");

        // Snapshot coherence with In0 moving and two drops.
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        start_frame(a, b, 1'b0);
        recv_frame(2, 1, 0, 1'b1, ab);
        check("drop_two", 64'(Drop_Cnt), 64'd2);
        after_fin("coh");

        // Random values and random ready.
        for (int f = 0; f < 3; f++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            start_frame(a, b, 1'b0);
            recv_frame(2, 0, 0, 1'b0, ab);
            after_fin($sformatf("rnd%0d", f));
        end
        check("drop_model", 64'(Drop_Cnt), 64'(exp_drop));

        // Reset after the 5th transfer.
        start_frame({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        recv_frame(0, 1, 5, 1'b0, ab);
        check("abort_reached", 64'(ab), 64'd1);
        Req = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        exp_drop = 0;
        check("mrst_valid", 64'(Tx_Valid), 64'd0);
        check("mrst_busy", 64'(Busy), 64'd0);
        check("mrst_drop", 64'(Drop_Cnt), 64'd0);
        check("mrst_done", 64'(Done), 64'd0);
        check("mrst_data", 64'(Tx_Data), 64'h00);
        @(negedge Clk);
        check("mrst_no_done", 64'(Done), 64'd0);

        // Fresh frame after reset.
        start_frame(64'h5, 64'h3, 1'b0);
        recv_frame(0, 0, 0, 1'b0, ab);
        after_fin("fresh");

        // Back-to-back with Req held high.
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        start_frame(a, b, 1'b1);
        recv_frame(2, 2, 0, 1'b0, ab);
        @(negedge Clk);
        check("b2b_gap_valid", 64'(Tx_Valid), 64'd1);
        check("b2b_done_low", 64'(Done), 64'd0);
        build_frame(a, b);
        recv_frame(0, 2, 0, 1'b0, ab);
        after_fin("b2b");
        check("b2b_drop", 64'(Drop_Cnt), 64'(exp_drop));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
